// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator side of a 32-bit ALU datapath. Takes one command at a time on
// a valid/ready request channel. It drives the ALU opcode/operand/carry
// ports from registers and waits LAT settle cycles per pass. It then
// captures the ALU result/carry and returns them on a valid/ready response
// channel. A 64-bit ("wide") NOT/AND/OR/XOR/ADD runs as two chained passes.
// For ADD, the low-pass carry-out feeds the high-pass carry-in.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both 1. The sender holds its payload stable
// while valid is 1 and ready is 0. Here, cmd_ready is only high in IDLE
// (and never while rst is high). rsp_valid is only high in RESP.
//
// Parameters:
//   LAT        ALU settle cycles per pass, 1..15
//
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
//   When defined, adds the rsp_zero output, registered alongside
//   rsp_result and equal to (rsp_result == 0).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          request handshake
//   cmd_op/a/b/cin/wide          command payload
//   alu_opcode/a/b/cin           registered drive to the ALU
//   alu_result/alu_cout          ALU outputs, sampled at the end of a pass
//   rsp_valid/rsp_ready          response handshake
//   rsp_result/rsp_cout          response payload
//   rsp_zero                     (macro only) result-is-zero flag
//   busy                         state != IDLE
//   dbg_state                    FSM state (0 IDLE, 1 DRIVE_LO, 2 DRIVE_HI, 3 RESP)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic        cmd_cin,
  input  logic        cmd_wide,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic        rsp_zero,
`endif
  output logic        busy,
  output logic [1:0]  dbg_state
);

  if (LAT < 1 || LAT > 15) begin : g_lat_range
    $error("alu_cmd_sequencer: LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  localparam logic [2:0] OP_ADD = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_LO = 2'd1,
    DRIVE_HI = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a_hi;
  logic [31:0] r_b_hi;
  logic        r_weff;
  logic [31:0] r_lo;
  logic [2:0]  r_alu_opcode;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_alu_cin;
  logic        r_rsp_valid;
  logic [63:0] r_rsp_result;
  logic        r_rsp_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        r_rsp_zero;
`endif

  logic w_weff;
  logic w_pass_done;
  logic w_is_add;

  // Shifts and CUT only have 32-bit meaning, so they ignore cmd_wide.
  assign w_weff      = cmd_wide && (cmd_op[2] == 1'b0 || cmd_op == OP_ADD);
  assign w_pass_done = (r_cnt == LAT_M1);
  assign w_is_add    = (r_op == OP_ADD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_op         <= 3'd0;
      r_a_hi       <= 32'd0;
      r_b_hi       <= 32'd0;
      r_weff       <= 1'b0;
      r_lo         <= 32'd0;
      r_alu_opcode <= 3'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_cin    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 64'd0;
      r_rsp_cout   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      r_rsp_zero   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // cmd_ready is high whenever IDLE and not in reset.
          if (cmd_valid) begin
            r_op         <= cmd_op;
            r_a_hi       <= cmd_a[63:32];
            r_b_hi       <= cmd_b[63:32];
            r_weff       <= w_weff;
            r_alu_opcode <= cmd_op;
            r_alu_a      <= cmd_a[31:0];
            r_alu_b      <= cmd_b[31:0];
            r_alu_cin    <= (cmd_op == OP_ADD) && cmd_cin;
            r_cnt        <= 4'd0;
            r_state      <= DRIVE_LO;
          end
        end

        DRIVE_LO: begin
          if (w_pass_done) begin
            r_cnt <= 4'd0;
            if (r_weff) begin
              r_lo      <= alu_result;
              r_alu_a   <= r_a_hi;
              r_alu_b   <= r_b_hi;
              // Chain the low-word carry into the high pass for ADD only.
              r_alu_cin <= w_is_add && alu_cout;
              r_state   <= DRIVE_HI;
            end else begin
              r_rsp_result <= {32'd0, alu_result};
              r_rsp_cout   <= w_is_add && alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
              r_rsp_zero   <= (alu_result == 32'd0);
`endif
              r_rsp_valid  <= 1'b1;
              r_state      <= RESP;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        DRIVE_HI: begin
          if (w_pass_done) begin
            r_cnt        <= 4'd0;
            r_rsp_result <= {alu_result, r_lo};
            r_rsp_cout   <= w_is_add && alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            r_rsp_zero   <= ({alu_result, r_lo} == 64'd0);
`endif
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == IDLE) && !rst;
  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cin    = r_alu_cin;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_cout   = r_rsp_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero   = r_rsp_zero;
`endif
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Two sequencers share one clock: u_dut0 with LAT=1 and u_dut1 with LAT=3.
// Each one has a behavioural 32-bit ALU attached. That ALU drives cout=1 on
// non-ADD ops, so the forced-zero rsp_cout path is exercised. Directed
// commands push their hand-computed result, carry, latency and accept cycle
// into a per-DUT expected queue. A negedge monitor pops and compares when it
// sees the response.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int EW = 113;  // {result[64], cout[1], latency[16], accept_cycle[32]}

  logic        clk;
  logic        rst        [2];
  logic        cmd_valid  [2];
  logic        cmd_ready  [2];
  logic [2:0]  cmd_op     [2];
  logic [63:0] cmd_a      [2];
  logic [63:0] cmd_b      [2];
  logic        cmd_cin    [2];
  logic        cmd_wide   [2];
  logic [2:0]  alu_opcode [2];
  logic [31:0] alu_a      [2];
  logic [31:0] alu_b      [2];
  logic        alu_cin    [2];
  logic [31:0] alu_result [2];
  logic        alu_cout   [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [63:0] rsp_result [2];
  logic        rsp_cout   [2];
  logic        rsp_zero   [2];
  logic        busy       [2];
  logic [1:0]  dbg_state  [2];

  logic [EW-1:0] exp_q [2][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_cyc   [2];

  logic        prev_hold [2];
  logic [63:0] prev_res  [2];
  logic        prev_cout [2];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  alu_cmd_sequencer #(.LAT(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_cin(cmd_cin[0]),
    .cmd_wide(cmd_wide[0]), .alu_opcode(alu_opcode[0]), .alu_a(alu_a[0]),
    .alu_b(alu_b[0]), .alu_cin(alu_cin[0]), .alu_result(alu_result[0]),
    .alu_cout(alu_cout[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_cout(rsp_cout[0]),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero(rsp_zero[0]),
`endif
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  alu_cmd_sequencer #(.LAT(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_cin(cmd_cin[1]),
    .cmd_wide(cmd_wide[1]), .alu_opcode(alu_opcode[1]), .alu_a(alu_a[1]),
    .alu_b(alu_b[1]), .alu_cin(alu_cin[1]), .alu_result(alu_result[1]),
    .alu_cout(alu_cout[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_cout(rsp_cout[1]),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero(rsp_zero[1]),
`endif
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

`ifndef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero[0] = 1'b0;
  assign rsp_zero[1] = 1'b0;
`endif

  // ---------------- ALU model ----------------
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    case (op)
      3'd0:    alu_f = {1'b1, ~a};
      3'd1:    alu_f = {1'b1, a & b};
      3'd2:    alu_f = {1'b1, a | b};
      3'd3:    alu_f = {1'b1, a ^ b};
      3'd4:    alu_f = {1'b1, a << b[4:0]};
      3'd5:    alu_f = {1'b1, a >> b[4:0]};
      3'd6:    alu_f = {1'b1, a & ~b};
      default: alu_f = {1'b0, a} + {1'b0, b} + {32'd0, c};
    endcase
  endfunction

  assign {alu_cout[0], alu_result[0]} = alu_f(alu_opcode[0], alu_a[0], alu_b[0], alu_cin[0]);
  assign {alu_cout[1], alu_result[1]} = alu_f(alu_opcode[1], alu_a[1], alu_b[1], alu_cin[1]);

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Issue one command on DUT k. Records the accept cycle and optionally
  // queues the expected response. Operands are scrambled after the accept
  // to show that the DUT captured them.
  task automatic send(input int k, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic cin, input logic wide,
                      input logic [63:0] er, input logic ec, input int lat,
                      input bit push, output int acc);
    bit got;
    got = 0;
    acc = -1;
    @(posedge clk); #1;
    cmd_op[k] = op; cmd_a[k] = a; cmd_b[k] = b; cmd_cin[k] = cin; cmd_wide[k] = wide;
    cmd_valid[k] = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready[k]) begin
        got = 1;
        acc = cyc;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout dut=%0d actual=no_accept required=accept", k);
    end else if (push) begin
      exp_q[k].push_back({er, ec, 16'(lat), 32'(acc)});
    end
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0;
    cmd_a[k] = ~a; cmd_b[k] = ~b; cmd_cin[k] = ~cin; cmd_op[k] = ~op;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 300 && exp_q[k].size() != 0; i++) @(negedge clk);
    chk($sformatf("drain_dut%0d", k), 64'(exp_q[k].size()), 64'd0);
  endtask

  task automatic wait_state(input int k, input logic [1:0] st, output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (dbg_state[k] == st) ok = 1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        prev_hold[k] = 1'b0;
      end else if (rsp_valid[k]) begin
        chk($sformatf("cmd_ready_in_resp_dut%0d", k), 64'(cmd_ready[k]), 64'd0);
        if (prev_hold[k]) begin
          chk($sformatf("hold_result_dut%0d", k), rsp_result[k], prev_res[k]);
          chk($sformatf("hold_cout_dut%0d", k), 64'(rsp_cout[k]), 64'(prev_cout[k]));
        end else if (exp_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp dut=%0d actual=valid required=no_response", k);
        end else begin
          logic [EW-1:0] e;
          e = exp_q[k][0];
          chk($sformatf("latency_dut%0d", k), 64'(cyc - int'(e[31:0])), 64'(e[47:32]));
        end
        if (rsp_ready[k] && exp_q[k].size() != 0) begin
          logic [EW-1:0] e;
          e = exp_q[k].pop_front();
          chk($sformatf("result_dut%0d", k), rsp_result[k], e[112:49]);
          chk($sformatf("cout_dut%0d", k), 64'(rsp_cout[k]), 64'(e[48]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
          chk($sformatf("zero_dut%0d", k), 64'(rsp_zero[k]), 64'(e[112:49] == 64'd0));
`endif
          hs_cyc[k] = cyc;
        end
        prev_hold[k] = !rsp_ready[k];
        prev_res[k]  = rsp_result[k];
        prev_cout[k] = rsp_cout[k];
      end else begin
        prev_hold[k] = 1'b0;
      end
    end
  end

  // ---------------- global timeout ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acc, acc2;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_op[k] = 3'd0; cmd_a[k] = 64'd0;
      cmd_b[k] = 64'd0; cmd_cin[k] = 1'b0; cmd_wide[k] = 1'b0; rsp_ready[k] = 1'b1;
      prev_hold[k] = 1'b0; hs_cyc[k] = -1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst_dut0", 64'(cmd_ready[0]), 64'd0);
    chk("ready_in_rst_dut1", 64'(cmd_ready[1]), 64'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_cmd_ready_dut%0d", k), 64'(cmd_ready[k]), 64'd1);
      chk($sformatf("rst_busy_dut%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("rst_rsp_valid_dut%0d", k), 64'(rsp_valid[k]), 64'd0);
      chk($sformatf("rst_rsp_result_dut%0d", k), rsp_result[k], 64'd0);
      chk($sformatf("rst_rsp_cout_dut%0d", k), 64'(rsp_cout[k]), 64'd0);
      chk($sformatf("rst_alu_opcode_dut%0d", k), 64'(alu_opcode[k]), 64'd0);
      chk($sformatf("rst_alu_a_dut%0d", k), 64'(alu_a[k]), 64'd0);
      chk($sformatf("rst_alu_b_dut%0d", k), 64'(alu_b[k]), 64'd0);
      chk($sformatf("rst_alu_cin_dut%0d", k), 64'(alu_cin[k]), 64'd0);
    end

    // LAT=1 narrow AND
    send(0, 3'b001, 64'h0000_0000_F0F0_F0F0, 64'h0000_0000_FF00_FF00, 1'b0, 1'b0,
         64'h0000_0000_F000_F000, 1'b0, 2, 1, acc);
    drain(0);

    // LAT=1 wide ADD, low carry chains into high pass
    send(0, 3'b111, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b1,
         64'h0000_0001_0000_0000, 1'b0, 3, 1, acc);
    wait_state(0, 2'd2, ok);
    chk("reach_drive_hi", 64'(ok), 64'd1);
    chk("hi_alu_cin", 64'(alu_cin[0]), 64'd1);
    chk("hi_alu_a", 64'(alu_a[0]), 64'd0);
    chk("hi_alu_opcode", 64'(alu_opcode[0]), 64'd7);
    drain(0);

    // Wide ADD overflow past bit 63
    send(0, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1,
         64'd0, 1'b1, 3, 1, acc);
    // Wide SHL runs as a single narrow pass
    send(0, 3'b100, 64'h1234_5678_0000_0001, 64'd4, 1'b0, 1'b1,
         64'h0000_0000_0000_0010, 1'b0, 2, 1, acc);
    // Wide XOR
    send(0, 3'b011, 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_FFFF_FFFF, 1'b0, 1'b1,
         64'hF0F0_0F0F_EDCB_A987, 1'b0, 3, 1, acc);
    // Narrow ADD with carry-out; upper operand bits ignored
    send(0, 3'b111, 64'hDEAD_0000_8000_0000, 64'h0000_BEEF_8000_0000, 1'b1, 1'b0,
         64'h0000_0000_0000_0001, 1'b1, 2, 1, acc);
    // Wide NOT
    send(0, 3'b000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0, 1'b1,
         64'hFFFF_FFFF_0000_0000, 1'b0, 3, 1, acc);
    drain(0);

    // Backpressure: hold rsp_ready low 5 cycles; the next command is queued
    // at the input and must be accepted exactly one cycle after the handshake.
    rsp_ready[0] = 1'b0;
    send(0, 3'b010, 64'h0000_0000_0000_1200, 64'h0000_0000_0000_0034, 1'b0, 1'b0,
         64'h0000_0000_0000_1234, 1'b0, 2, 1, acc);
    fork
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (rsp_valid[0]) seen = 1;
        end
        chk("bp_rsp_seen", 64'(seen), 64'd1);
        repeat (5) @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
      end
      send(0, 3'b000, 64'h0000_0000_0F0F_0F0F, 64'd0, 1'b0, 1'b0,
           64'h0000_0000_F0F0_F0F0, 1'b0, 2, 1, acc2);
    join
    chk("bp_next_accept_cycle", 64'(acc2), 64'(hs_cyc[0] + 1));
    drain(0);

    // LAT=3 narrow XOR
    send(1, 3'b011, 64'h0000_0000_AAAA_5555, 64'h0000_0000_FFFF_0000, 1'b0, 1'b0,
         64'h0000_0000_5555_5555, 1'b0, 4, 1, acc);
    // LAT=3 wide ADD with low-word carry
    send(1, 3'b111, 64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 1'b0, 1'b1,
         64'h0000_0003_0000_0000, 1'b0, 7, 1, acc);
    drain(1);

    // Reset during DRIVE_HI of a wide ADD: command dropped, no response
    send(1, 3'b111, 64'h0000_0001_FFFF_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b1,
         64'd0, 1'b0, 7, 0, acc);
    wait_state(1, 2'd2, ok);
    chk("rst_mid_reach_hi", 64'(ok), 64'd1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_low", 64'(cmd_ready[1]), 64'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_state_idle", 64'(dbg_state[1]), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready[1]), 64'd1);
    repeat (12) @(negedge clk);
    chk("rst_mid_no_rsp", 64'(rsp_valid[1]), 64'd0);
    // Recovery after reset
    send(1, 3'b001, 64'h0000_0000_1234_5678, 64'h0000_0000_0F0F_0F0F, 1'b0, 1'b0,
         64'h0000_0000_0204_0608, 1'b0, 4, 1, acc);
    drain(1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
